// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and
// the default bit period used by both the TX and RX sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // 100 MHz clock / 115200 baud
  localparam int UART_BAUD_CYCLE = 868;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data. The head entry is
// always visible on dout, so a consumer can pop and use the byte on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstB,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes are queued in a FIFO and serialised
// back-to-back with no idle gap while the FIFO still holds data.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLE = UART_BAUD_CYCLE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstB,
  input  logic       dataEn,
  input  logic [7:0] dataIn,
  output logic       FfFull,
  output logic       FfEmpty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int CW = (BAUD_CYCLE > 1) ? $clog2(BAUD_CYCLE) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_reg, state_next;
  logic [CW-1:0]             baud_reg, baud_next;
  logic [2:0]                bit_reg, bit_next;
  logic [7:0]                shift_reg, shift_next;
  logic                      tx_reg, tx_next;
  logic                      overflow_reg;
  logic                      pop;
  logic                      tc;
  logic [7:0]                fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstB  (rstB),
    .push  (dataEn),
    .din   (dataIn),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tc       = (baud_reg == BAUD_LAST);
  assign FfFull   = fifo_full;
  assign FfEmpty  = (fifo_count == '0);
  assign busy     = (state_reg != IDLE);
  assign tx       = tx_reg;
  assign overflow = overflow_reg;

  // State, counters, shift register and the registered serial output.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      // Fullness is judged before the edge, so a write while full is dropped
      // even if a pop happens on the same edge.
      overflow_reg <= dataEn && fifo_full;
    end
  end

  // Frame sequencing: next state, counter updates, popping and the next tx level.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tc) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (tc) begin
          baud_next = '0;
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_reg + 1'b1;
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        baud_next  = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a frame-level reference model
// predicts every output each cycle and a serial decoder recovers the bytes.
module tb_uart_tx_buffered;

  localparam int BC    = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * BC;

  logic       clk = 1'b0;
  logic       rstB = 1'b0;
  logic       dataEn = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       FfFull, FfEmpty, busy, overflow, tx;

  int errors = 0;
  int checks = 0;

  uart_tx_buffered #(
    .BAUD_CYCLE (BC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rstB     (rstB),
    .dataEn   (dataEn),
    .dataIn   (dataIn),
    .FfFull   (FfFull),
    .FfEmpty  (FfEmpty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buffer of accepted bytes (indices grow forever, storage wraps mod 256),
  // plus one "frame in flight" with its elapsed time since the start edge.
  logic [7:0] mq [256];
  int         m_head = 0;
  int         m_tail = 0;
  int         m_cnt;
  logic       m_active = 1'b0;
  int         m_elapsed = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_end, m_start;
  logic       e_tx;
  logic [2:0] e_idx;
  logic [4:0] dut_v, exp_v;

  assign m_cnt   = m_tail - m_head;
  assign m_end   = m_active && (m_elapsed == FRAME - 1);
  assign m_start = (m_cnt != 0) && (!m_active || m_end);
  assign e_idx   = 3'((m_elapsed / BC) - 1);

  always_comb begin
    e_tx = 1'b1;
    if (m_active) begin
      if (m_elapsed < BC)          e_tx = 1'b0;
      else if (m_elapsed < 9 * BC) e_tx = m_byte[e_idx];
    end
  end

  assign dut_v = {tx, busy, FfFull, FfEmpty, overflow};
  assign exp_v = {e_tx, m_active, (m_cnt == DEPTH), (m_cnt == 0), m_ovf};

  always @(posedge clk) begin
    if (!rstB) begin
      m_head    <= 0;
      m_tail    <= 0;
      m_active  <= 1'b0;
      m_elapsed <= 0;
      m_ovf     <= 1'b0;
    end else begin
      m_ovf <= dataEn && (m_cnt == DEPTH);
      if (dataEn && (m_cnt != DEPTH)) begin
        mq[m_tail % 256] <= dataIn;
        m_tail <= m_tail + 1;
      end
      if (m_start) begin
        m_byte    <= mq[m_head % 256];
        m_head    <= m_head + 1;
        m_active  <= 1'b1;
        m_elapsed <= 0;
      end else if (m_end) begin
        m_active  <= 1'b0;
        m_elapsed <= 0;
      end else if (m_active) begin
        m_elapsed <= m_elapsed + 1;
      end
    end
  end

  // ---------------- serial decoder ----------------
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (rstB && tx === 1'b0) begin
        repeat (BC / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int b = 0; b < 8; b++) begin
            repeat (BC) @(negedge clk);
            rx_byte[b] = tx;
          end
          repeat (BC) @(negedge clk);
          rx_q.push_back(rx_byte);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rstB = 1'b0;
    dataEn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_v !== 5'b10010) begin
      errors++;
      $display("FAIL reset_values: got {tx,busy,full,empty,ovf}=%b expected 10010", dut_v);
    end
    rstB = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_v !== 5'b10010) begin
      errors++;
      $display("FAIL after_release: got %b expected 10010", dut_v);
    end
    $display("test_reset: tx=%b busy=%b empty=%b", tx, busy, FfEmpty);
  endtask

  task automatic test_loopback(input logic [7:0] val);
    int busy_cnt;
    rx_q.delete();
    dataEn = 1'b1;
    dataIn = val;
    @(negedge clk);
    dataEn = 1'b0;
    dataIn = 8'($urandom);
    checks++;
    if ({FfEmpty, tx, busy} !== 3'b010) begin
      errors++;
      $display("FAIL push_edge: got {empty,tx,busy}=%b expected 010", {FfEmpty, tx, busy});
    end
    @(negedge clk);
    checks++;
    if ({FfEmpty, tx, busy} !== 3'b101) begin
      errors++;
      $display("FAIL start_edge: got {empty,tx,busy}=%b expected 101", {FfEmpty, tx, busy});
    end
    busy_cnt = 1;
    for (int c = 0; c < FRAME + 20; c++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL loopback_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt != FRAME) begin
      errors++;
      $display("FAIL loopback_busy_len: got %0d expected %0d", busy_cnt, FRAME);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== val) begin
      errors++;
      $display("FAIL loopback_rx: got %0d bytes first=%h expected 1 byte %h",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, val);
    end
    $display("test_loopback: sent %h busy_cycles=%0d", val, busy_cnt);
  endtask

  task automatic test_bit_timing();
    logic want;
    dataEn = 1'b1;
    dataIn = 8'h01;
    @(negedge clk);
    dataEn = 1'b0;
    for (int t = 1; t <= FRAME + 1; t++) begin
      @(negedge clk);
      if (t <= BC)              want = 1'b0;
      else if (t <= 2 * BC)     want = 1'b1;
      else if (t <= 9 * BC)     want = 1'b0;
      else                      want = 1'b1;
      checks++;
      if (tx !== want) begin
        errors++;
        $display("FAIL bit_timing_t%0d: got tx=%b expected %b", t, tx, want);
      end
    end
    $display("test_bit_timing: frame of 0x01 checked over %0d cycles", FRAME + 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    int busy_cnt;
    int rises;
    logic prev_busy;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    rx_q.delete();
    busy_cnt = 0;
    rises = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 3 * FRAME + 40; c++) begin
      dataEn = (c < 3);
      dataIn = (c < 3) ? vals[c] : 8'($urandom);
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
      if (busy) busy_cnt++;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    dataEn = 1'b0;
    checks++;
    if (busy_cnt != 3 * FRAME || rises != 1) begin
      errors++;
      $display("FAIL b2b_contiguous: got busy=%0d rises=%0d expected %0d and 1",
               busy_cnt, rises, 3 * FRAME);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q.size() != 3 || rx_q[i] !== vals[i]) begin
        errors++;
        $display("FAIL b2b_rx%0d: got %h (of %0d) expected %h", i,
                 (rx_q.size() > i) ? rx_q[i] : 8'hxx, rx_q.size(), vals[i]);
      end
    end
    $display("test_back_to_back: busy=%0d rx=%0d", busy_cnt, rx_q.size());
  endtask

  task automatic test_overflow();
    logic [7:0] vals [10];
    int ovf_cnt;
    rx_q.delete();
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) vals[i] = 8'($urandom);
    for (int c = 0; c < 9 * FRAME + 40; c++) begin
      dataEn = (c < 10);
      dataIn = (c < 10) ? vals[c] : 8'h00;
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL ovf_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
      if (c == 8) begin
        checks++;
        if (FfFull !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full_after_9: got %b expected 1", FfFull);
        end
      end
      if (overflow) ovf_cnt++;
    end
    dataEn = 1'b0;
    checks++;
    if (ovf_cnt != 1) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt);
    end
    checks++;
    if (rx_q.size() != 9) begin
      errors++;
      $display("FAIL ovf_rx_count: got %0d expected 9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== vals[i]) begin
          errors++;
          $display("FAIL ovf_rx%0d: got %h expected %h", i, rx_q[i], vals[i]);
        end
      end
    end
    $display("test_overflow: pulses=%0d rx=%0d", ovf_cnt, rx_q.size());
  endtask

  task automatic test_reset_mid();
    dataEn = 1'b1;
    dataIn = 8'($urandom);
    @(negedge clk);
    dataEn = 1'b0;
    // land in the middle of data bit 3
    repeat (1 + 4 * BC + BC / 2) @(negedge clk);
    rstB = 1'b0;
    @(negedge clk);
    rstB = 1'b1;
    checks++;
    if ({tx, busy, FfEmpty} !== 3'b101) begin
      errors++;
      $display("FAIL reset_mid: got {tx,busy,empty}=%b expected 101", {tx, busy, FfEmpty});
    end
    for (int c = 0; c < 12 * BC; c++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
    end
    rx_q.delete();
    dataEn = 1'b1;
    dataIn = 8'h5A;
    @(negedge clk);
    dataEn = 1'b0;
    for (int c = 0; c < FRAME + 20; c++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL reset_frame_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_rx: got %0d bytes first=%h expected 1 byte 5a",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    $display("test_reset_mid: post-reset frame rx=%0d", rx_q.size());
  endtask

  task automatic test_random();
    int base;
    int n;
    rx_q.delete();
    base = m_tail;
    for (int c = 0; c < 3000 + 9 * FRAME + 40; c++) begin
      dataEn = (c < 3000) && ($urandom_range(0, 99) < 4);
      dataIn = 8'($urandom);
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", c, dut_v, exp_v);
      end
    end
    dataEn = 1'b0;
    n = m_tail - base;
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL random_rx_count: got %0d expected %0d", rx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_q[i] !== mq[(base + i) % 256]) begin
          errors++;
          $display("FAIL random_rx%0d: got %h expected %h", i, rx_q[i], mq[(base + i) % 256]);
        end
      end
    end
    $display("test_random: accepted=%0d received=%0d", n, rx_q.size());
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy} !== 2'b10) begin
        errors++;
        bad++;
        $display("FAIL idle_cycle%0d: got {tx,busy}=%b expected 10", c, {tx, busy});
      end
    end
    $display("test_idle: 2000 cycles, deviations=%0d", bad);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_loopback(8'hA5);
    test_bit_timing();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
